stopwatch_sec: RTL and testbench



---
 rtl/timer_pkg.sv | 14 +
 rtl/sec_prescaler.sv | 39 +++
 rtl/stopwatch_sec.sv | 115 +++++++++++
 tb/tb_stopwatch_sec.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the second-based timing blocks (stopwatch and countdown timer):
// the control state encoding and the default timing/width constants.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } timer_state_t;

    localparam int TICKS_PER_SEC_DEFAULT = 5;
    localparam int WIDTH_DEFAULT         = 16;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to one-second strobes. The count advances while
// enabled, is held while disabled, and is forced to zero by clr. The sec_tick
// output is high in the cycle whose closing edge wraps the count, so a consumer
// registering on that same edge sees the second boundary with no extra latency.
module sec_prescaler
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sec_tick
);

    localparam int              PW   = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]   LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] count;

    assign sec_tick = en && !clr && (count == LAST);

    // Sub-second counter: clear wins, otherwise count 0..TICKS_PER_SEC-1 while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + PW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_sec.sv
// Count-up elapsed-seconds stopwatch with start/stop/clear control, saturating
// count with sticky overflow, and optional lap capture.
// Build option: define STOPWATCH_LAP_EN to build the lap capture register;
// without it lap is ignored and lap_time/lap_valid are tied to zero.
module stopwatch_sec
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT,
    parameter int WIDTH         = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             lap,
    output logic [WIDTH-1:0] elapsed,
    output logic [WIDTH-1:0] lap_time,
    output logic             lap_valid,
    output logic             running,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    timer_state_t state;
    timer_state_t state_next;
    logic         presc_en;
    logic         presc_clr;
    logic         sec_tick;

    // The prescaler only moves in RUN; it is zeroed by clear and on a fresh start
    // from IDLE, but a resume from PAUSED keeps the preserved fraction.
    assign presc_en  = (state == RUN);
    assign presc_clr = clear || ((state == IDLE) && start);

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (presc_en),
        .clr      (presc_clr),
        .sec_tick (sec_tick)
    );

    // Control state register with the registered running flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
        end
    end

    // Next-state decode: clear beats stop, stop beats start
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (stop)  state_next = PAUSED;
                PAUSED:  if (start) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Elapsed seconds: saturate at all-ones and latch overflow until cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elapsed  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            elapsed  <= '0;
            overflow <= 1'b0;
        end else if (sec_tick) begin
            if (elapsed == MAX_COUNT) begin
                overflow <= 1'b1;
            end else begin
                elapsed <= elapsed + WIDTH'(1);
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_capture;

    assign lap_capture = lap && !clear && ((state == RUN) || (state == PAUSED));

    // Lap register takes the pre-edge elapsed value; lap_time survives a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_time  <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= lap_capture;
            if (lap_capture) begin
                lap_time <= elapsed;
            end
        end
    end
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign lap_time   = '0;
    assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_sec.sv
// Directed testbench for stopwatch_sec: reset behaviour, counting, pause/resume,
// lap capture, control priority, and saturation on a narrow instance.
module tb_stopwatch_sec;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start, stop, clear, lap;
    logic [15:0] elapsed, lap_time;
    logic        lap_valid, running, overflow;

    logic        start4, clear4, lap4;
    logic [3:0]  elapsed4, lap_time4;
    logic        lap_valid4, running4, overflow4;

    int n_asserts = 0;
    int n_fail    = 0;

    stopwatch_sec #(.TICKS_PER_SEC(5), .WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .elapsed(elapsed), .lap_time(lap_time), .lap_valid(lap_valid),
        .running(running), .overflow(overflow)
    );

    stopwatch_sec #(.TICKS_PER_SEC(5), .WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .stop(1'b0), .clear(clear4), .lap(lap4),
        .elapsed(elapsed4), .lap_time(lap_time4), .lap_valid(lap_valid4),
        .running(running4), .overflow(overflow4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic p, input logic c, input logic l);
        start = s;
        stop  = p;
        clear = c;
        lap   = l;
    endtask

    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        start4 = 1'b0; clear4 = 1'b0; lap4 = 1'b0;

        stepEdges(2);
        checkOutput("rst_elapsed",   32'(elapsed),   0);
        checkOutput("rst_running",   32'(running),   0);
        checkOutput("rst_lap_time",  32'(lap_time),  0);
        checkOutput("rst_lap_valid", 32'(lap_valid), 0);
        checkOutput("rst_overflow",  32'(overflow),  0);

        rst = 1'b0;
        applyStimulus(1, 0, 0, 0);
        stepEdges(1);
        checkOutput("pre_rst_running", 32'(running), 1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(6);
        checkOutput("pre_rst_elapsed", 32'(elapsed), 1);

        // Asynchronous reset between edges with start held high
        applyStimulus(1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_elapsed", 32'(elapsed), 0);
        checkOutput("async_rst_running", 32'(running), 0);
        stepEdges(1);
        checkOutput("rst_hold_running", 32'(running), 0);
        applyStimulus(0, 0, 0, 0);
        rst = 1'b0;
        stepEdges(3);
        checkOutput("post_rst_idle_elapsed", 32'(elapsed), 0);
        checkOutput("post_rst_idle_running", 32'(running), 0);

        // One-cycle start, then 25 counting edges
        applyStimulus(1, 0, 0, 0);
        stepEdges(1);
        checkOutput("start_running", 32'(running), 1);
        checkOutput("start_elapsed", 32'(elapsed), 0);
        applyStimulus(0, 0, 0, 0);
        stepEdges(4);
        checkOutput("edge4_elapsed", 32'(elapsed), 0);
        stepEdges(1);
        checkOutput("edge5_elapsed", 32'(elapsed), 1);
        stepEdges(20);
        checkOutput("edge25_elapsed", 32'(elapsed), 5);
        checkOutput("edge25_running", 32'(running), 1);

        applyStimulus(0, 0, 1, 0);
        stepEdges(1);
        checkOutput("clear_elapsed", 32'(elapsed), 0);
        checkOutput("clear_running", 32'(running), 0);

        // Pause after 7 running edges; fraction 2 must survive the pause
        applyStimulus(1, 0, 0, 0);
        stepEdges(1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(6);
        applyStimulus(0, 1, 0, 0);
        stepEdges(1);
        checkOutput("stop_elapsed", 32'(elapsed), 1);
        checkOutput("stop_running", 32'(running), 0);
        stepEdges(9);
        checkOutput("paused_elapsed", 32'(elapsed), 1);
        applyStimulus(1, 0, 0, 0);
        stepEdges(1);
        checkOutput("resume_running", 32'(running), 1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(2);
        checkOutput("resume2_elapsed", 32'(elapsed), 1);
        stepEdges(1);
        checkOutput("resume3_elapsed", 32'(elapsed), 2);

        // Lap on the 3->4 tick edge
        stepEdges(9);
        checkOutput("pre_lap_elapsed", 32'(elapsed), 3);
        applyStimulus(0, 0, 0, 1);
        stepEdges(1);
        checkOutput("lap_tick_elapsed",  32'(elapsed),   4);
        checkOutput("lap_tick_lap_time", 32'(lap_time),  LAP_EN ? 3 : 0);
        checkOutput("lap_tick_valid",    32'(lap_valid), LAP_EN ? 1 : 0);
        applyStimulus(0, 0, 0, 0);
        stepEdges(1);
        checkOutput("lap_pulse_end", 32'(lap_valid), 0);
        checkOutput("lap_time_kept", 32'(lap_time),  LAP_EN ? 3 : 0);

        // Lap held for two edges recaptures each time
        applyStimulus(0, 0, 0, 1);
        stepEdges(2);
        checkOutput("lap_held_valid", 32'(lap_valid), LAP_EN ? 1 : 0);
        checkOutput("lap_held_time",  32'(lap_time),  LAP_EN ? 4 : 0);

        // Clear keeps lap_time; lap in IDLE is ignored
        applyStimulus(0, 0, 1, 0);
        stepEdges(1);
        checkOutput("clear2_elapsed",  32'(elapsed),   0);
        checkOutput("clear2_valid",    32'(lap_valid), 0);
        checkOutput("clear2_lap_time", 32'(lap_time),  LAP_EN ? 4 : 0);
        applyStimulus(0, 0, 0, 1);
        stepEdges(1);
        checkOutput("idle_lap_valid", 32'(lap_valid), 0);
        checkOutput("idle_lap_time",  32'(lap_time),  LAP_EN ? 4 : 0);

        // All controls at once while running: clear wins
        applyStimulus(1, 0, 0, 0);
        stepEdges(1);
        applyStimulus(0, 0, 0, 0);
        stepEdges(2);
        checkOutput("prio_pre_running", 32'(running), 1);
        applyStimulus(1, 1, 1, 1);
        stepEdges(1);
        checkOutput("prio_running",  32'(running),   0);
        checkOutput("prio_elapsed",  32'(elapsed),   0);
        checkOutput("prio_valid",    32'(lap_valid), 0);
        checkOutput("prio_lap_time", 32'(lap_time),  LAP_EN ? 4 : 0);
        applyStimulus(0, 0, 0, 0);
        stepEdges(6);
        checkOutput("prio_idle_elapsed", 32'(elapsed), 0);

        // Saturation on the 4-bit instance
        start4 = 1'b1;
        stepEdges(1);
        start4 = 1'b0;
        stepEdges(75);
        checkOutput("w4_elapsed_15",  32'(elapsed4),  15);
        checkOutput("w4_overflow_0",  32'(overflow4), 0);
        stepEdges(5);
        checkOutput("w4_sat_elapsed", 32'(elapsed4),  15);
        checkOutput("w4_sat_overflow", 32'(overflow4), 1);
        checkOutput("w4_sat_running", 32'(running4),  1);
        stepEdges(10);
        checkOutput("w4_sticky_overflow", 32'(overflow4), 1);
        lap4 = 1'b1;
        stepEdges(1);
        lap4 = 1'b0;
        checkOutput("w4_lap_time", 32'(lap_time4), LAP_EN ? 15 : 0);
        clear4 = 1'b1;
        stepEdges(1);
        clear4 = 1'b0;
        checkOutput("w4_clear_elapsed",  32'(elapsed4),  0);
        checkOutput("w4_clear_overflow", 32'(overflow4), 0);
        checkOutput("w4_clear_lap_time", 32'(lap_time4), LAP_EN ? 15 : 0);
        checkOutput("w4_clear_running",  32'(running4),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
